ram18_ctrl: RTL

Request-side controller for the 32x512 1rw1r SRAM macro wrapper. It accepts a valid/ready read/write request stream and drives port 0 of the macro (csb0, web0, wmask0, addr0, din0). It captures dout0 at the macro's fixed read latency and returns read data through a 4-entry response FIFO with valid/ready backpressure. It sits between the bus/core logic and the RAM instance; port 1 is parked.

---
 rtl/ram18_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ram18_ctrl.sv
// ram18_ctrl: request-side controller for the 32x512 1rw1r SRAM macro wrapper.
// Drives macro port 0 from a valid/ready request stream, tracks reads through a
// two-stage valid pipeline matching the macro latency, and returns read data
// through a small credit-managed response FIFO. Port 1 is parked.
// Optional build macro RAM18_CTRL_CLEAR_EN: zero-fill the whole array after
// reset before accepting requests.
module ram18_ctrl #(
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_wmask,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        init_done,
  output logic        csb0,
  output logic        web0,
  output logic [3:0]  wmask0,
  output logic [8:0]  addr0,
  output logic [31:0] din0,
  input  logic [31:0] dout0,
  output logic        csb1,
  output logic [8:0]  addr1
);

  logic        w_init_done;
  logic        w_clr_active;
  logic [8:0]  w_clr_addr;

`ifdef RAM18_CTRL_CLEAR_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t      r_state, w_state_nxt;
  logic [8:0]  r_clr_addr, w_clr_addr_nxt;

  // Clear-sweep state register; reset restarts the sweep at address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  // Sweep one word per cycle, then hand over to normal request traffic.
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_clr_active   = 1'b0;
    w_init_done    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_clr_active   = 1'b1;
        w_clr_addr_nxt = r_clr_addr + 9'd1;
        if (r_clr_addr == 9'h1FF) w_state_nxt = ST_RUN;
      end
      ST_RUN: w_init_done = 1'b1;
      default: ;
    endcase
  end

  assign w_clr_addr = r_clr_addr;
`else
  assign w_init_done  = 1'b1;
  assign w_clr_active = 1'b0;
  assign w_clr_addr   = '0;
`endif

  logic        r_s1, r_s2;
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;
  logic [31:0] r_last;
  logic [31:0] r_fifo [RSP_DEPTH];
  logic        r_csb0, r_web0;
  logic [3:0]  r_wmask0;
  logic [8:0]  r_addr0;
  logic [31:0] r_din0;

  logic [1:0]  w_inflight;
  logic [2:0]  w_occ;
  logic        w_req_ready, w_req_acc, w_rd_acc, w_push, w_pop, w_rsp_valid;

  // Credit: every read in flight or buffered owns a FIFO slot, so a push can
  // never find the FIFO full. Writes obey the same gate to keep ordering trivial.
  assign w_inflight  = {1'b0, r_s1} + {1'b0, r_s2};
  assign w_occ       = r_count + {1'b0, w_inflight};
  assign w_req_ready = w_init_done && (w_occ < 3'(RSP_DEPTH));
  assign w_req_acc   = req_valid && w_req_ready;
  assign w_rd_acc    = w_req_acc && !req_we;
  assign w_push      = r_s2;
  assign w_rsp_valid = (r_count != 3'd0);
  assign w_pop       = w_rsp_valid && rsp_ready;

  // Read valid pipeline: s1 = macro sampling, s2 = dout0 ready to capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= w_rd_acc;
      r_s2 <= r_s1;
    end
  end

  // Response FIFO pointers, occupancy and last-popped data for the empty case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
        r_last   <= r_fifo[r_rd_ptr];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Response FIFO storage; entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= dout0;
  end

  // Macro port 0 registers; address/data/mask hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_csb0   <= 1'b1;
      r_web0   <= 1'b1;
      r_wmask0 <= '0;
      r_addr0  <= '0;
      r_din0   <= '0;
    end else if (w_clr_active) begin
      r_csb0   <= 1'b0;
      r_web0   <= 1'b0;
      r_wmask0 <= 4'hF;
      r_addr0  <= w_clr_addr;
      r_din0   <= '0;
    end else if (w_req_acc) begin
      r_csb0   <= 1'b0;
      r_web0   <= !req_we;
      r_wmask0 <= req_wmask;
      r_addr0  <= req_addr;
      r_din0   <= req_wdata;
    end else begin
      r_csb0   <= 1'b1;
      r_web0   <= 1'b1;
    end
  end

  assign req_ready = w_req_ready;
  assign init_done = w_init_done;
  assign rsp_valid = w_rsp_valid;
  assign rsp_rdata = w_rsp_valid ? r_fifo[r_rd_ptr] : r_last;
  assign csb0      = r_csb0;
  assign web0      = r_web0;
  assign wmask0    = r_wmask0;
  assign addr0     = r_addr0;
  assign din0      = r_din0;
  assign csb1      = 1'b1;
  assign addr1     = '0;

endmodule
